// File: rtl/aes128_cipher_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, ten rounds per block.
// Optional build macro AES128_CIPHER_KEY_LATCH_EN captures rk1..rk10 at accept.
module aes128_cipher_iter (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [0:127]  plaintext,
    input  logic [0:1407] keyschedule,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [0:127]  ciphertext,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // FIPS-197 S-box, entry x at bits [8x +: 8].
    localparam logic [0:2047] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return sbox_table[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [0:127] sub_bytes(input logic [0:127] s);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return r;
    endfunction

    // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
    function automatic logic [0:127] shift_rows(input logic [0:127] s);
        logic [0:127] r;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[8*(4*c + w) +: 8] = s[8*(4*((c + w) % 4) + w) +: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [0:127] mix_columns(input logic [0:127] s);
        logic [0:127] r;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            r[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    fsm_t          fsm, fsm_next;
    logic [0:127]  state;
    logic [3:0]    round;
    logic [0:127]  ct_reg;
    logic [0:1279] rk_src;
    logic [0:127]  sr_out;
    logic [0:127]  mc_out;
    logic [0:127]  round_key;
    logic [0:127]  round_out;
    logic          accept;
    logic          round_ok;

`ifdef AES128_CIPHER_KEY_LATCH_EN
    logic [0:1279] key_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
        end else if (accept) begin
            key_reg <= keyschedule[128 +: 1280];
        end
    end

    assign rk_src = key_reg;
`else
    assign rk_src = keyschedule[128 +: 1280];
`endif

    assign accept   = in_valid && in_ready;
    assign round_ok = (round >= 4'd1) && (round <= 4'd10);

    // NOTE: every variable gets a default before the case/loop so no latch is inferred.
    always_comb begin
        sr_out    = shift_rows(sub_bytes(state));
        mc_out    = mix_columns(sr_out);
        round_key = '0;
        for (int r = 1; r <= 10; r++) begin
            if (round == 4'(r)) begin
                round_key = rk_src[128*(r-1) +: 128];
            end
        end
        round_out = ((round == 4'd10) ? sr_out : mc_out) ^ round_key;
    end

    always_comb begin
        fsm_next  = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (round == 4'd10)  fsm_next = DONE;
                else if (!round_ok)  fsm_next = IDLE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm    <= IDLE;
            state  <= '0;
            round  <= '0;
            ct_reg <= '0;
        end else begin
            fsm <= fsm_next;
            if (accept) begin
                state <= plaintext ^ keyschedule[0 +: 128];
                round <= 4'd1;
            end else if (fsm == RUN && round_ok) begin
                state <= round_out;
                if (round == 4'd10) begin
                    ct_reg <= round_out;
                end else begin
                    round <= round + 4'd1;
                end
            end
        end
    end

    assign ciphertext = ct_reg;

endmodule

// File: tb/tb_aes128_cipher_iter.sv
// Scoreboard bench for aes128_cipher_iter using FIPS-197 vectors.
// Honours AES128_CIPHER_KEY_LATCH_EN to exercise the key-capture build.
module tb_aes128_cipher_iter;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [0:127]  plaintext;
    logic [0:1407] keyschedule;
    logic          out_valid;
    logic          out_ready;
    logic [0:127]  ciphertext;
    logic          busy;

    aes128_cipher_iter dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .plaintext   (plaintext),
        .keyschedule (keyschedule),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ciphertext  (ciphertext),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam logic [0:2047] sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        return sbox_table[{b, 3'b000} +: 8];
    endfunction

    // Reference of the upstream 128-bit key expansion block.
    function automatic logic [0:1407] expand_key(input logic [0:127] key);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1407] ks;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ks[32*i +: 32] = w[i];
        return ks;
    endfunction

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           acc_cyc;
    int           a1, a2;
    logic [0:127] exp_q [$];
    logic [0:127] mon_exp;

    logic [0:127]  pt_c1, ct_c1, pt_b, ct_b;
    logic [0:1407] ks_c1, ks_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare at every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", {127'b0, out_valid}, 128'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("ciphertext", ciphertext, mon_exp);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [0:127] pt, input logic [0:1407] ks,
                        input logic [0:127] exp, input bit hold);
        int n = 0;
        in_valid    = 1'b1;
        plaintext   = pt;
        keyschedule = ks;
        exp_q.push_back(exp);
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", {127'b0, in_ready}, 128'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_timeout", {127'b0, out_valid}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        pt_c1 = 128'h00112233445566778899aabbccddeeff;
        ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ks_c1 = expand_key(128'h000102030405060708090a0b0c0d0e0f);
        pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
        ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
        ks_b  = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        plaintext = '0; keyschedule = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready",   {127'b0, in_ready},  128'd1);
        check("rst_out_valid",  {127'b0, out_valid}, 128'd0);
        check("rst_busy",       {127'b0, busy},      128'd0);
        check("rst_ciphertext", ciphertext,          128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 C.1, latency 10; latch build also scrambles the key after accept.
        send(pt_c1, ks_c1, ct_c1, 1'b0);
`ifdef AES128_CIPHER_KEY_LATCH_EN
        @(posedge clk); #1;
        keyschedule = '0;
`endif
        wait_valid();
        check("c1_latency", 128'(cyc - acc_cyc), 128'd10);
        @(negedge clk);
        check("c1_back_idle", {126'b0, in_ready, out_valid}, 128'b10);

        // FIPS-197 App. B with 20 cycles of backpressure.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(pt_b, ks_b, ct_b, 1'b0);
        wait_valid();
        check("b_latency", 128'(cyc - acc_cyc), 128'd10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_flags", {125'b0, out_valid, in_ready, busy}, 128'b101);
            check("stall_ciphertext", ciphertext, ct_b);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_still_done", {126'b0, out_valid, in_ready}, 128'b10);
        @(negedge clk);
        check("release_idle", {126'b0, out_valid, in_ready}, 128'b01);

        // Back-to-back: App. B then C.1 with in_valid held high.
        @(posedge clk); #1;
        send(pt_b, ks_b, ct_b, 1'b1);
        a1 = acc_cyc;
        wait_valid();
        plaintext   = pt_c1;
        keyschedule = ks_c1;
        exp_q.push_back(ct_c1);
        begin
            int n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        check("b2b_accept_timeout", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;
        a2 = cyc;
        in_valid = 1'b0;
        check("b2b_interval", 128'(a2 - a1), 128'd12);
        wait_valid();
        check("b2b_latency", 128'(cyc - a2), 128'd10);

        // Reset while round 5 is loaded, then a fresh C.1.
        @(posedge clk); #1;
        send(pt_c1, ks_c1, ct_c1, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready",   {127'b0, in_ready},  128'd1);
        check("midrst_out_valid",  {127'b0, out_valid}, 128'd0);
        check("midrst_busy",       {127'b0, busy},      128'd0);
        check("midrst_ciphertext", ciphertext,          128'd0);
        @(posedge clk); #1;
        send(pt_c1, ks_c1, ct_c1, 1'b0);
        wait_valid();
        check("post_rst_latency", 128'(cyc - acc_cyc), 128'd10);

        repeat (3) @(negedge clk);
        check("pending_outputs", 128'(exp_q.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_cipher_iter.md
# aes128_cipher_iter

Iterative AES-128 encryption core that consumes the 1408-bit round-key schedule from the combinational 128-bit key expansion block and runs one cipher round per clock. It sits directly downstream of key expansion. It accepts one plaintext block through a valid/ready handshake and returns the ciphertext through a second valid/ready handshake after ten round cycles.

## Interface
- No parameters. Nb=4, Nr=10 and Nk=4 are fixed.
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  plaintext and keyschedule valid.
- in_ready  out  1  block can accept; high only in IDLE.
- plaintext  in  [0:127]  input block; bit 0 is the MSB; byte k = bits [8k +: 8]; column-major (byte k = row k%4, col k/4).
- keyschedule  in  [0:1407]  round key r = keyschedule[128r +: 128], r = 0..10, same byte order as plaintext.
- out_valid  out  1  ciphertext valid.
- out_ready  in  1  consumer takes the ciphertext.
- ciphertext  out  [0:127]  result, same byte order as plaintext.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset value is IDLE.
- Datapath registers: 128-bit state, 4-bit round counter, 128-bit ciphertext register.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: state <= plaintext ^ rk0; round <= 1; go to RUN.
- RUN:
  - Each cycle: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[round]); round <= round + 1.
  - When round == 10, MixColumns is skipped. The result is written to the ciphertext register and to state; go to DONE.
- DONE:
  - out_valid = 1; ciphertext is held stable.
  - On out_ready: go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- SubBytes uses 16 parallel combinational FIPS-197 S-box lookups.
- MixColumns uses xtime: {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0). All arithmetic is GF(2^8).
- ShiftRows rotates row r left by r columns.
- The round counter never exceeds 10; values 11-15 are unreachable. If reached, the FSM returns to IDLE.
- keyschedule must be held stable by the upstream block from the accept cycle until out_valid. The exception is described under Configuration.
- in_valid while not in IDLE is ignored; there is no buffering.
- Reset mid-operation: all state returns to reset values within one cycle, and any partial result is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, ciphertext=0, state=0, round=0.
- Latency: accept edge T → out_valid high after edge T+10 (10 RUN cycles).
- Minimum initiation interval is 12 cycles: accept, 10 rounds, one DONE cycle with out_ready=1, then IDLE.
- out_ready held low stalls DONE indefinitely with ciphertext stable.
- Outputs are registered. in_ready, out_valid and busy decode directly from the FSM register.

## Configuration
- Macro: AES128_CIPHER_KEY_LATCH_EN.
- Defined:
  - At accept, keyschedule[128 +: 1280] (rk1..rk10) is captured into an internal register, and rounds read from that copy.
  - Upstream may change keyschedule any time after the accept edge.
  - The capture register resets to 0.
- Undefined:
  - No key register is built; rounds read keyschedule directly.
  - The caller must hold keyschedule stable until out_valid.
  - Latency and handshake are identical in both builds.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f expanded by the 128-bit key expansion block; plaintext 00112233445566778899aabbccddeeff → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after accept.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c; plaintext 3243f6a8885a308d313198a2e0370734 → ciphertext 3925841d02dc09fbdc118597196a0b32.
- Backpressure: out_ready low for 20 cycles after out_valid → ciphertext and out_valid steady, in_ready=0; first cycle with out_ready=1 → IDLE next cycle.
- Back-to-back: two blocks with in_valid held high and out_ready=1 → second accept exactly 12 cycles after the first; both ciphertexts correct.
- Reset at round 5 → next cycle in_ready=1, out_valid=0, ciphertext=0; a fresh C.1 encryption then completes correctly.
- With AES128_CIPHER_KEY_LATCH_EN defined: change keyschedule to all zeros one cycle after accepting C.1 → ciphertext still 69c4e0d86a7b0430d8cdb78070b4c55a.
